siso_link_controller: RTL and testbench

- Sequencer for a SISO shift-register chain of fixed latency.
- Accepts a parallel word over a valid/ready handshake and serialises it MSB-first onto the chain input.
- Captures the bits returning on the chain output into a receive word, compares it with the sent word, and presents result plus mismatch flag over a second valid/ready handshake.
- Sits between the bus-side test/config logic and the serial register instance; used for loopback checking and for moving words through the chain.

---
 rtl/siso_link_controller_if.sv | 59 +++++
 rtl/siso_link_controller.sv | 195 +++++++++++++++++++
 tb/tb_siso_link_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/siso_link_controller_if.sv
// Signal bundle between siso_link_controller and its bus-side / chain-side neighbours.
// rx_parity_err is present only when SISO_LINK_PARITY_EN is defined.
interface siso_link_controller_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_mismatch;
    logic             rx_valid;
    logic             rx_ready;
    logic             abort;
    logic             sr_serial_in;
    logic             sr_clear;
    logic             sr_serial_out;
    logic             busy;
`ifdef SISO_LINK_PARITY_EN
    logic             rx_parity_err;
`endif

    // Bus-side producer/consumer together with the serial chain.
    modport master (
        output tx_data,
        output tx_valid,
        output rx_ready,
        output abort,
        output sr_serial_out,
        input  tx_ready,
        input  rx_data,
        input  rx_mismatch,
        input  rx_valid,
        input  sr_serial_in,
        input  sr_clear,
        input  busy
`ifdef SISO_LINK_PARITY_EN
        , input rx_parity_err
`endif
    );

    // The link controller itself.
    modport slave (
        input  tx_data,
        input  tx_valid,
        input  rx_ready,
        input  abort,
        input  sr_serial_out,
        output tx_ready,
        output rx_data,
        output rx_mismatch,
        output rx_valid,
        output sr_serial_in,
        output sr_clear,
        output busy
`ifdef SISO_LINK_PARITY_EN
        , output rx_parity_err
`endif
    );
endinterface

// File: rtl/siso_link_controller.sv
// Serialises a word MSB-first through a fixed-latency shift-register chain and checks the return.
// Optional macro SISO_LINK_PARITY_EN appends an even-parity bit to every frame.
module siso_link_controller #(
    parameter int WIDTH      = 8,
    parameter int SR_LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    siso_link_controller_if.slave link
);
`ifdef SISO_LINK_PARITY_EN
    localparam int FRAME_W = WIDTH + 1;
`else
    localparam int FRAME_W = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + SR_LATENCY + 1);
    localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(SR_LATENCY);
    localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(SR_LATENCY + FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

`ifdef SISO_LINK_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        even_parity = ^word;
    endfunction
`endif

    logic [1:0]         state_r,       state_s;
    logic [CNT_W-1:0]   cnt_r,         cnt_s;
    logic [FRAME_W-1:0] shadow_r,      shadow_s;
    logic [WIDTH-1:0]   cmp_r,         cmp_s;
    logic [FRAME_W-2:0] rx_sh_r,       rx_sh_s;
    logic [WIDTH-1:0]   rx_data_r,     rx_data_s;
    logic               rx_mismatch_r, rx_mismatch_s;
    logic               rx_valid_r,    rx_valid_s;
    logic               tx_ready_r,    tx_ready_s;
    logic               sr_in_r,       sr_in_s;
    logic               sr_clear_r,    sr_clear_s;
    logic               busy_r,        busy_s;
    logic               clr_pend_r;
`ifdef SISO_LINK_PARITY_EN
    logic               par_err_r,     par_err_s;
`endif
    logic [FRAME_W-1:0] tx_frame_s;
    logic [FRAME_W-1:0] cap_s;
    logic [WIDTH-1:0]   cap_word_s;
    logic               abort_s;

`ifdef SISO_LINK_PARITY_EN
    assign tx_frame_s = {link.tx_data, even_parity(link.tx_data)};
    assign cap_word_s = cap_s[FRAME_W-1:1];
`else
    assign tx_frame_s = link.tx_data;
    assign cap_word_s = cap_s;
`endif
    // cap_s is the receive register as it looks after this cycle's capture.
    assign cap_s   = {rx_sh_r, link.sr_serial_out};
    assign abort_s = link.abort && (state_r != ST_IDLE);

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        shadow_s      = shadow_r;
        cmp_s         = cmp_r;
        rx_sh_s       = rx_sh_r;
        rx_data_s     = rx_data_r;
        rx_mismatch_s = rx_mismatch_r;
        rx_valid_s    = rx_valid_r;
        tx_ready_s    = tx_ready_r;
        sr_in_s       = 1'b0;
        sr_clear_s    = clr_pend_r;
`ifdef SISO_LINK_PARITY_EN
        par_err_s     = par_err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                tx_ready_s = 1'b1;
                if (link.tx_valid && tx_ready_r) begin
                    state_s    = ST_SHIFT;
                    cnt_s      = {CNT_W{1'b0}};
                    shadow_s   = {tx_frame_s[FRAME_W-2:0], 1'b0};
                    cmp_s      = link.tx_data;
                    sr_in_s    = tx_frame_s[FRAME_W-1];
                    tx_ready_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sr_in_s  = shadow_r[FRAME_W-1];
                shadow_s = {shadow_r[FRAME_W-2:0], 1'b0};
                if (cnt_r >= CAP_FIRST) begin
                    rx_sh_s = cap_s[FRAME_W-2:0];
                end else begin
                    rx_sh_s = rx_sh_r;
                end
                if (cnt_r == CAP_LAST) begin
                    state_s       = ST_DONE;
                    rx_valid_s    = 1'b1;
                    rx_data_s     = cap_word_s;
                    rx_mismatch_s = (cap_word_s != cmp_r);
`ifdef SISO_LINK_PARITY_EN
                    par_err_s     = even_parity(cap_word_s) ^ cap_s[0];
`endif
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                if (link.rx_ready) begin
                    state_s    = ST_IDLE;
                    rx_valid_s = 1'b0;
                    tx_ready_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                rx_valid_s = 1'b0;
                tx_ready_s = 1'b1;
            end
        endcase
        // Abort overrides everything, including a simultaneous rx_ready in DONE.
        if (abort_s) begin
            state_s       = ST_IDLE;
            rx_valid_s    = 1'b0;
            rx_mismatch_s = 1'b0;
            rx_data_s     = rx_data_r;
            tx_ready_s    = 1'b1;
            sr_in_s       = 1'b0;
            sr_clear_s    = 1'b1;
`ifdef SISO_LINK_PARITY_EN
            par_err_s     = 1'b0;
`endif
        end else begin
            sr_clear_s = clr_pend_r;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; clr_pend_r stretches sr_clear one cycle past reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            shadow_r      <= {FRAME_W{1'b0}};
            cmp_r         <= {WIDTH{1'b0}};
            rx_sh_r       <= {(FRAME_W-1){1'b0}};
            rx_data_r     <= {WIDTH{1'b0}};
            rx_mismatch_r <= 1'b0;
            rx_valid_r    <= 1'b0;
            tx_ready_r    <= 1'b1;
            sr_in_r       <= 1'b0;
            sr_clear_r    <= 1'b1;
            busy_r        <= 1'b0;
            clr_pend_r    <= 1'b1;
`ifdef SISO_LINK_PARITY_EN
            par_err_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            shadow_r      <= shadow_s;
            cmp_r         <= cmp_s;
            rx_sh_r       <= rx_sh_s;
            rx_data_r     <= rx_data_s;
            rx_mismatch_r <= rx_mismatch_s;
            rx_valid_r    <= rx_valid_s;
            tx_ready_r    <= tx_ready_s;
            sr_in_r       <= sr_in_s;
            sr_clear_r    <= sr_clear_s;
            busy_r        <= busy_s;
            clr_pend_r    <= 1'b0;
`ifdef SISO_LINK_PARITY_EN
            par_err_r     <= par_err_s;
`endif
        end
    end

    assign link.tx_ready     = tx_ready_r;
    assign link.rx_data      = rx_data_r;
    assign link.rx_mismatch  = rx_mismatch_r;
    assign link.rx_valid     = rx_valid_r;
    assign link.sr_serial_in = sr_in_r;
    assign link.sr_clear     = sr_clear_r;
    assign link.busy         = busy_r;
`ifdef SISO_LINK_PARITY_EN
    assign link.rx_parity_err = par_err_r;
`endif
endmodule

// File: tb/tb_siso_link_controller.sv
// Bench for siso_link_controller: ideal delay-line chain with injectable stuck/flip faults,
// table vectors, hand sequences (hold, abort) and randomized transfers against a word-level model.
module tb_siso_link_controller;
    localparam int W   = 8;
    localparam int LAT = 5;
`ifdef SISO_LINK_PARITY_EN
    localparam int POFF = 1;
`else
    localparam int POFF = 0;
`endif
    localparam int FW = W + POFF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    siso_link_controller_if #(.WIDTH(W)) link();
    siso_link_controller #(.WIDTH(W), .SR_LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .link(link));

    int checks = 0;
    int failures = 0;

    logic [LAT-1:0] chain;
    int             k;
    logic [W-1:0]   stuck_m = '0;
    logic [W-1:0]   flip_m  = '0;
    logic           flip_par = 1'b0;

    // Ideal chain: LAT registers, cleared synchronously by sr_clear; k = cycles since SHIFT began.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            k     <= 0;
        end else begin
            if (link.sr_clear) chain <= '0;
            else               chain <= {chain[LAT-2:0], link.sr_serial_in};
            k <= link.busy ? k + 1 : 0;
        end
    end

    // Frame bit p comes back out of the chain at k = LAT + FW-1-p; faults are applied there.
    always_comb begin
        logic o;
        o = chain[LAT-1];
        for (int b = 0; b < W; b++) begin
            if (k == LAT + FW - 1 - (b + POFF)) o = (o | stuck_m[b]) ^ flip_m[b];
        end
        if (POFF == 1 && flip_par && k == LAT + FW - 1) o = ~o;
        link.sr_serial_out = o;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Starts at the negedge of the first SHIFT cycle (cnt=0); ends in IDLE after consumption.
    task automatic collect(input logic [W-1:0] word, input logic [W-1:0] exp_data,
                           input logic exp_mis, input logic exp_perr, input int rdy_wait,
                           input bit hold_next, input logic [W-1:0] next_word);
        int c;
        bit seen;
        int good_hold;
        logic [FW+LAT-1:0] bits;
        logic [FW+LAT-1:0] exp_bits;
        c = 1;
        seen = 0;
        bits = '0;
        exp_bits = '0;
        for (int j = 0; j < FW + LAT; j++) begin
            if (j < W)                      exp_bits[FW+LAT-1-j] = word[W-1-j];
            else if (POFF == 1 && j == W)   exp_bits[FW+LAT-1-j] = ^word;
            else                            exp_bits[FW+LAT-1-j] = 1'b0;
        end
        check("busy_in_shift", {31'd0, link.busy}, 32'd1);
        check("tx_ready_in_shift", {31'd0, link.tx_ready}, 32'd0);
        while (c <= 4 * (FW + LAT) && !seen) begin
            if (c <= FW + LAT) bits[FW+LAT-c] = link.sr_serial_in;
            if (link.rx_valid) seen = 1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        check("rx_valid_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("latency", c, FW + LAT + 1);
            check("serial_bits", 32'(bits), 32'(exp_bits));
            check("rx_data", 32'(link.rx_data), 32'(exp_data));
            check("rx_mismatch", {31'd0, link.rx_mismatch}, {31'd0, exp_mis});
`ifdef SISO_LINK_PARITY_EN
            check("rx_parity_err", {31'd0, link.rx_parity_err}, {31'd0, exp_perr});
`endif
            if (hold_next) begin
                link.tx_data  = next_word;
                link.tx_valid = 1'b1;
            end
            good_hold = 0;
            for (int i = 0; i < rdy_wait; i++) begin
                @(negedge clk);
                if (link.rx_valid && !link.tx_ready && link.rx_data == exp_data) good_hold++;
            end
            check("hold_done", good_hold, rdy_wait);
            link.rx_ready = 1'b1;
            @(negedge clk);
            link.rx_ready = 1'b0;
            check("rx_valid_after_consume", {31'd0, link.rx_valid}, 32'd0);
            check("tx_ready_after_consume", {31'd0, link.tx_ready}, 32'd1);
            check("busy_after_consume", {31'd0, link.busy}, 32'd0);
        end
    endtask

    task automatic send(input logic [W-1:0] word, input logic [W-1:0] exp_data,
                        input logic exp_mis, input logic exp_perr, input int rdy_wait);
        check("tx_ready_idle", {31'd0, link.tx_ready}, 32'd1);
        link.tx_data  = word;
        link.tx_valid = 1'b1;
        @(negedge clk);
        link.tx_valid = 1'b0;
        collect(word, exp_data, exp_mis, exp_perr, rdy_wait, 1'b0, '0);
    endtask

    function automatic logic model_perr(input logic [W-1:0] word, input logic [W-1:0] ret,
                                        input logic fp);
        return (POFF == 1) ? ((^ret) ^ (^word) ^ fp) : 1'b0;
    endfunction

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] stuck;
        logic [W-1:0] flip;
        logic [W-1:0] exp_data;
        logic         exp_mis;
        int           rdy_wait;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int no_valid;
        logic [W-1:0] w, s, f, r;
        logic fp;
        vecs[0] = '{word: 8'hA5, stuck: 8'h00, flip: 8'h00, exp_data: 8'hA5, exp_mis: 1'b0, rdy_wait: 0};
        vecs[1] = '{word: 8'h00, stuck: 8'h08, flip: 8'h00, exp_data: 8'h08, exp_mis: 1'b1, rdy_wait: 2};
        vecs[2] = '{word: 8'hFF, stuck: 8'h00, flip: 8'h00, exp_data: 8'hFF, exp_mis: 1'b0, rdy_wait: 1};
        vecs[3] = '{word: 8'h3C, stuck: 8'h00, flip: 8'h81, exp_data: 8'hBD, exp_mis: 1'b1, rdy_wait: 0};
        vecs[4] = '{word: 8'h5A, stuck: 8'h00, flip: 8'h00, exp_data: 8'h5A, exp_mis: 1'b0, rdy_wait: 3};

        link.tx_data = '0; link.tx_valid = 1'b0; link.rx_ready = 1'b0; link.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", {31'd0, link.tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, link.rx_valid}, 32'd0);
        check("rst_sr_clear", {31'd0, link.sr_clear}, 32'd1);
        check("rst_sr_serial_in", {31'd0, link.sr_serial_in}, 32'd0);
        check("rst_busy", {31'd0, link.busy}, 32'd0);
        check("rst_rx_data", 32'(link.rx_data), 32'd0);
        check("rst_rx_mismatch", {31'd0, link.rx_mismatch}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("sr_clear_post_reset", {31'd0, link.sr_clear}, 32'd1);
        @(negedge clk);
        check("sr_clear_released", {31'd0, link.sr_clear}, 32'd0);

        link.abort = 1'b1;
        @(negedge clk);
        link.abort = 1'b0;
        check("idle_abort_no_clear", {31'd0, link.sr_clear}, 32'd0);
        check("idle_abort_ready", {31'd0, link.tx_ready}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            stuck_m = vecs[i].stuck;
            flip_m  = vecs[i].flip;
            send(vecs[i].word, vecs[i].exp_data, vecs[i].exp_mis,
                 model_perr(vecs[i].word, vecs[i].exp_data, 1'b0), vecs[i].rdy_wait);
        end
        stuck_m = '0;
        flip_m  = '0;

        // Result held in DONE while the next word waits, then accepted on the first IDLE cycle.
        link.tx_data = 8'hA5; link.tx_valid = 1'b1;
        @(negedge clk);
        link.tx_valid = 1'b0;
        collect(8'hA5, 8'hA5, 1'b0, 1'b0, 10, 1'b1, 8'h3C);
        @(negedge clk);
        link.tx_valid = 1'b0;
        collect(8'h3C, 8'h3C, 1'b0, 1'b0, 0, 1'b0, '0);

        // Abort at cnt=6.
        link.tx_data = 8'h55; link.tx_valid = 1'b1;
        @(negedge clk);
        link.tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        link.abort = 1'b1;
        @(negedge clk);
        link.abort = 1'b0;
        check("abort_busy", {31'd0, link.busy}, 32'd0);
        check("abort_tx_ready", {31'd0, link.tx_ready}, 32'd1);
        check("abort_rx_valid", {31'd0, link.rx_valid}, 32'd0);
        check("abort_sr_clear", {31'd0, link.sr_clear}, 32'd1);
        check("abort_sr_serial_in", {31'd0, link.sr_serial_in}, 32'd0);
        check("abort_rx_data_kept", 32'(link.rx_data), 32'h3C);
        @(negedge clk);
        check("abort_sr_clear_pulse", {31'd0, link.sr_clear}, 32'd0);
        no_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (!link.rx_valid) no_valid++;
            @(negedge clk);
        end
        check("abort_no_rx_valid", no_valid, 20);
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 0);

`ifdef SISO_LINK_PARITY_EN
        send(8'h07, 8'h07, 1'b0, 1'b0, 0);
        flip_par = 1'b1;
        send(8'h07, 8'h07, 1'b0, 1'b1, 0);
        flip_par = 1'b0;
`endif

        for (int i = 0; i < 40; i++) begin
            w  = 8'($urandom);
            s  = ($urandom_range(0, 3) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
            f  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
            fp = (POFF == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            r  = (w | s) ^ f;
            stuck_m  = s;
            flip_m   = f;
            flip_par = fp;
            send(w, r, (r != w), model_perr(w, r, fp), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
